bus_decode_dtack: RTL and testbench
===================================

BUS_DECODE_DTACK -- requirements
Module: bus_decode_dtack

Interface
- REQ-001 Parameter NREG, default 16: number of decode regions.
- REQ-002 Parameter AW, default 24: CPU address width.
- REQ-003 Parameter DBITS, default 20: low address bits compared; bits above DBITS are ignored, which mirrors the map.
- REQ-004 Parameter WSW, default 4: wait-state counter width.
- REQ-005 Port clk, in, 1: system clock. One clock; reset is synchronous and active-high.
- REQ-006 Port reset, in, 1: synchronous active-high reset.
- REQ-007 Ports cpu_a (in, AW), cpu_as_n (in, 1), cpu_rw (in, 1): 68K address, address strobe, read=1.
- REQ-008 Ports cfg_we (in, 1), cfg_idx (in, $clog2(NREG)): region table write strobe and region index.
- REQ-009 Ports cfg_start (in, DBITS), cfg_end (in, DBITS), cfg_ws (in, WSW): table write data; region range is inclusive.
- REQ-010 Ports cfg_rd_en, cfg_wr_en, cfg_ext, cfg_valid (in, 1 each): table write data; cfg_ext means the region is acknowledged by the external device.
- REQ-011 Port ext_ack (in, 1): completion from a slow device such as SDRAM.
- REQ-012 Port sel (out, NREG): registered one-hot region select.
- REQ-013 Ports sel_idx (out, $clog2(NREG)) and hit (out, 1): encoded selected region and a valid flag.
- REQ-014 Port dtack_n (out, 1): data acknowledge to the CPU.

Function
- REQ-015 Region table SHALL hold NREG entries; cfg_we SHALL write entry cfg_idx on the next clock edge.
- REQ-016 Match rule: valid AND start<=a[DBITS-1:0]<=end AND (rw ? rd_en : wr_en).
- REQ-017 On multiple matches, the lowest index SHALL win.
- REQ-018 FSM states: IDLE, DECODE, WAIT, ACK.
- REQ-019 IDLE->DECODE: on the first clk with cpu_as_n=0. The address and the table entry are latched in this state, so later table writes affect only the next bus cycle.
- REQ-020 DECODE->WAIT on a hit: sel, sel_idx and hit are asserted 1 clk after AS low is sampled, and the counter is loaded with ws.
- REQ-021 DECODE on a miss: with no hit, the FSM SHALL stay in DECODE with sel=0 and dtack_n=1 until AS goes high (or REQ-029 applies).
- REQ-022 WAIT: count down to 0. ws=0 SHALL give dtack_n=0 two clks after AS low is sampled.
- REQ-023 WAIT with ext=1: after the count expires, the FSM SHALL also wait for ext_ack=1. An ext_ack that arrives early SHALL be remembered (sticky) for the current cycle.
- REQ-024 ACK: dtack_n=0 and sel held until cpu_as_n=1. On that clk the FSM SHALL go to IDLE, and sel, hit and dtack_n deassert on the following edge.
- REQ-025 AS rising in any state SHALL abort to IDLE without asserting dtack_n.
- REQ-026 Back-to-back cycles: AS low sampled in IDLE SHALL start a new decode, with no idle bubble required beyond the AS-high clk.

Reset
- REQ-027 Reset SHALL put the FSM in IDLE with sel=0, sel_idx=0, hit=0, dtack_n=1, counter=0, sticky ack=0, berr_n=1, and all table valid bits=0. Start, end and ws values need not be reset.
- REQ-028 Reset mid-cycle SHALL override everything, and outputs idle on the next edge.

Configuration
- REQ-029 When macro BUS_DECODE_BERR_EN is defined: output berr_n (1 bit) is added, plus a timeout counter of 256 clks in DECODE (miss) or WAIT. On expiry, berr_n=0 until AS goes high. When the macro is undefined, there is no berr_n port and a miss waits indefinitely.

Structure
- REQ-030 Package bus_decode_pkg SHALL hold the FSM state enum, the region entry struct (start, end, ws, rd_en, wr_en, ext, valid) and the BERR_TIMEOUT=256 constant.
- REQ-031 Sub-module region_match SHALL be a combinational priority matcher producing a one-hot vector plus an index, instantiated once.

Verification
- REQ-032 Scenario: entry0 = 0x00000-0x7FFFF, ws=0, read AS low at 0x012340 -> sel[0]=1 at +1 clk, dtack_n=0 at +2 clk.
- REQ-033 Scenario: entry3 = 0xF0000-0xFFFFF, ws=3; access 0x1F0010 (mirror) -> hit, idx 3, dtack_n=0 at +5 clk.
- REQ-034 Scenario: entry1 and entry2 overlap at 0x88000 -> sel=0b0010, sel_idx=1.
- REQ-035 Scenario: ext region with ext_ack pulsed at +1 clk (before the count ends, ws=2) -> dtack_n=0 at +4 clk from the sticky ack.
- REQ-036 Scenario: write to an rd-only region -> hit=0, dtack_n stays 1; with BUS_DECODE_BERR_EN, berr_n=0 after 256 clks.
- REQ-037 Scenario: reset asserted in WAIT -> next edge sel=0, dtack_n=1, FSM in IDLE, table invalid.

Source files
------------

// File: rtl/bus_decode_dtack_pkg.sv
// bus_decode_pkg: shared types and constants for the 68K address decoder /
// DTACK generator.
//   state_t        - decode FSM states (IDLE, DECODE, WAIT, ACK)
//   region_t       - one region table entry. Its fields are sized for the
//                    widest supported configuration (32 address bits,
//                    8 wait-state bits). Users narrow it with size casts.
//   BERR_TIMEOUT   - bus-error timeout in clocks (used with BUS_DECODE_BERR_EN)
//   region_hit()   - match rule for one entry against an address/direction
package bus_decode_pkg;

    localparam int BERR_TIMEOUT  = 256;
    localparam int REGION_ADDR_W = 32;
    localparam int REGION_WS_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_WAIT   = 2'd2,
        ST_ACK    = 2'd3
    } state_t;

    typedef struct packed {
        logic [REGION_ADDR_W-1:0] start_addr;
        logic [REGION_ADDR_W-1:0] end_addr;
        logic [REGION_WS_W-1:0]   ws;
        logic                     rd_en;
        logic                     wr_en;
        logic                     ext;
        logic                     valid;
    } region_t;

    // Range is inclusive on both ends. The direction enable follows the 68K
    // convention (rw=1 is a read).
    function automatic logic region_hit(input region_t r,
                                        input logic [REGION_ADDR_W-1:0] a,
                                        input logic rw);
        return r.valid && (a >= r.start_addr) && (a <= r.end_addr) &&
               (rw ? r.rd_en : r.wr_en);
    endfunction

endpackage

// File: rtl/bus_decode_dtack_if.sv
// bus_decode_dtack_if: CPU-side bus bundle of the decoder.
//   cpu_a, cpu_as_n, cpu_rw - 68K address, address strobe (active low), read=1
//   ext_ack                 - completion from a slow external device
//   sel, sel_idx, hit       - registered one-hot select, encoded index, valid
//   dtack_n                 - data acknowledge to the CPU (active low)
//   berr_n                  - bus error (active low), only with BUS_DECODE_BERR_EN
// Modports: master = CPU/system side, slave = the decoder.
//
// Handshake: a bus cycle starts at the first clock that samples cpu_as_n=0.
// It ends at the first clock that samples cpu_as_n=1. dtack_n (or berr_n)
// is asserted low by the decoder and stays low until the strobe is released.
interface bus_decode_dtack_if #(
    parameter int NREG = 16,
    parameter int AW   = 24
);
    logic [AW-1:0]           cpu_a;
    logic                    cpu_as_n;
    logic                    cpu_rw;
    logic                    ext_ack;
    logic [NREG-1:0]         sel;
    logic [$clog2(NREG)-1:0] sel_idx;
    logic                    hit;
    logic                    dtack_n;
`ifdef BUS_DECODE_BERR_EN
    logic                    berr_n;

    modport master (output cpu_a, cpu_as_n, cpu_rw, ext_ack,
                    input  sel, sel_idx, hit, dtack_n, berr_n);
    modport slave  (input  cpu_a, cpu_as_n, cpu_rw, ext_ack,
                    output sel, sel_idx, hit, dtack_n, berr_n);
`else
    modport master (output cpu_a, cpu_as_n, cpu_rw, ext_ack,
                    input  sel, sel_idx, hit, dtack_n);
    modport slave  (input  cpu_a, cpu_as_n, cpu_rw, ext_ack,
                    output sel, sel_idx, hit, dtack_n);
`endif
endinterface

// File: rtl/bus_decode_dtack_region_match.sv
// region_match: combinational priority matcher over the region table.
//   tbl    - region table entries
//   addr   - low DBITS address bits to compare
//   rw     - access direction (1 = read)
//   onehot - one-hot vector of the winning entry (all zero on a miss)
//   idx    - encoded index of the winning entry (0 on a miss)
//   hit    - at least one entry matched
// When several entries match, the lowest index wins.
module region_match
    import bus_decode_pkg::*;
#(
    parameter int NREG  = 16,
    parameter int DBITS = 20
) (
    input  region_t                 tbl [NREG],
    input  logic [DBITS-1:0]        addr,
    input  logic                    rw,
    output logic [NREG-1:0]         onehot,
    output logic [$clog2(NREG)-1:0] idx,
    output logic                    hit
);
    localparam int IW = $clog2(NREG);

    logic [REGION_ADDR_W-1:0] a_ext;
    assign a_ext = REGION_ADDR_W'(addr);

    // Scan from the top down so a lower matching index overwrites a higher one.
    always_comb begin
        onehot = '0;
        idx    = '0;
        hit    = 1'b0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (region_hit(tbl[i], a_ext, rw)) begin
                onehot    = '0;
                onehot[i] = 1'b1;
                idx       = IW'(i);
                hit       = 1'b1;
            end
        end
    end

    // The ws/ext fields are consumed by the FSM, not by the matcher.
    logic unused_fields;
    always_comb begin
        unused_fields = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            unused_fields = unused_fields ^ (^tbl[i].ws) ^ tbl[i].ext;
        end
    end

endmodule

// File: rtl/bus_decode_dtack.sv
// bus_decode_dtack: programmable 68K address decoder with DTACK generation.
//   clk, reset      - system clock, synchronous active-high reset
//   cfg_we, cfg_idx - region table write strobe and entry index
//   cfg_start/end   - inclusive region range (low DBITS address bits)
//   cfg_ws          - wait states before DTACK
//   cfg_rd_en/wr_en - direction enables; cfg_ext = external completion needed
//   cfg_valid       - entry valid
//   bus             - CPU bus bundle (slave modport)
//   dbg_state       - current FSM state
// Optional feature: define BUS_DECODE_BERR_EN to add bus.berr_n and a
// BERR_TIMEOUT-clock timeout in DECODE (miss) and WAIT.
//
// Timing from the clock that samples cpu_as_n low (edge 0):
//   edge 1      sel/sel_idx/hit valid, wait counter loaded
//   edge 2+ws   dtack_n low (later for ext regions until ext_ack is seen)
// Address bits at DBITS and above are ignored, so regions mirror.
module bus_decode_dtack
    import bus_decode_pkg::*;
#(
    parameter int NREG  = 16,
    parameter int AW    = 24,
    parameter int DBITS = 20,
    parameter int WSW   = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cfg_we,
    input  logic [$clog2(NREG)-1:0] cfg_idx,
    input  logic [DBITS-1:0]        cfg_start,
    input  logic [DBITS-1:0]        cfg_end,
    input  logic [WSW-1:0]          cfg_ws,
    input  logic                    cfg_rd_en,
    input  logic                    cfg_wr_en,
    input  logic                    cfg_ext,
    input  logic                    cfg_valid,
    bus_decode_dtack_if.slave       bus,
    output state_t                  dbg_state
);
    localparam int IW = $clog2(NREG);

    // ---------------- region table ----------------
    // Only valid bits are reset. Range and wait-state fields are don't-care
    // until their entry is written.
    region_t tbl [NREG];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                tbl[i].valid <= 1'b0;
            end
        end else if (cfg_we) begin
            tbl[cfg_idx].start_addr <= REGION_ADDR_W'(cfg_start);
            tbl[cfg_idx].end_addr   <= REGION_ADDR_W'(cfg_end);
            tbl[cfg_idx].ws         <= REGION_WS_W'(cfg_ws);
            tbl[cfg_idx].rd_en      <= cfg_rd_en;
            tbl[cfg_idx].wr_en      <= cfg_wr_en;
            tbl[cfg_idx].ext        <= cfg_ext;
            tbl[cfg_idx].valid      <= cfg_valid;
        end
    end

    // ---------------- matcher ----------------
    logic [NREG-1:0] m_oh;
    logic [IW-1:0]   m_idx;
    logic            m_hit;

    region_match #(.NREG(NREG), .DBITS(DBITS)) u_match (
        .tbl    (tbl),
        .addr   (bus.cpu_a[DBITS-1:0]),
        .rw     (bus.cpu_rw),
        .onehot (m_oh),
        .idx    (m_idx),
        .hit    (m_hit)
    );

    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.cpu_a[AW-1:DBITS];

    // ---------------- FSM ----------------
    state_t          state;
    logic [NREG-1:0] lat_oh;
    logic [IW-1:0]   lat_idx;
    logic            lat_hit;
    logic [WSW-1:0]  lat_ws;
    logic            lat_ext;
    logic [WSW-1:0]  cnt;
    logic            sticky_ack;
    logic [NREG-1:0] sel_q;
    logic [IW-1:0]   sel_idx_q;
    logic            hit_q;
    logic            dtack_n_q;

    // The decode result is captured on the strobe edge. Table writes made
    // during a bus cycle therefore apply only from the next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            lat_oh     <= '0;
            lat_idx    <= '0;
            lat_hit    <= 1'b0;
            lat_ws     <= '0;
            lat_ext    <= 1'b0;
            cnt        <= '0;
            sticky_ack <= 1'b0;
            sel_q      <= '0;
            sel_idx_q  <= '0;
            hit_q      <= 1'b0;
            dtack_n_q  <= 1'b1;
        end else if (state != ST_IDLE && bus.cpu_as_n) begin
            // Strobe released: end or abort the cycle without acknowledging.
            state      <= ST_IDLE;
            cnt        <= '0;
            sticky_ack <= 1'b0;
            sel_q      <= '0;
            sel_idx_q  <= '0;
            hit_q      <= 1'b0;
            dtack_n_q  <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    sticky_ack <= 1'b0;
                    if (!bus.cpu_as_n) begin
                        state   <= ST_DECODE;
                        lat_oh  <= m_oh;
                        lat_idx <= m_idx;
                        lat_hit <= m_hit;
                        lat_ws  <= WSW'(tbl[m_idx].ws);
                        lat_ext <= tbl[m_idx].ext;
                    end
                end
                ST_DECODE: begin
                    if (bus.ext_ack) sticky_ack <= 1'b1;
                    // A miss parks here until the strobe goes away.
                    if (lat_hit) begin
                        state     <= ST_WAIT;
                        sel_q     <= lat_oh;
                        sel_idx_q <= lat_idx;
                        hit_q     <= 1'b1;
                        cnt       <= lat_ws;
                    end
                end
                ST_WAIT: begin
                    if (bus.ext_ack) sticky_ack <= 1'b1;
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (!lat_ext || sticky_ack || bus.ext_ack) begin
                        state     <= ST_ACK;
                        dtack_n_q <= 1'b0;
                    end
                end
                ST_ACK: begin
                    // Hold select and acknowledge until the strobe is released.
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.sel     = sel_q;
    assign bus.sel_idx = sel_idx_q;
    assign bus.hit     = hit_q;
    assign bus.dtack_n = dtack_n_q;
    assign dbg_state   = state;

`ifdef BUS_DECODE_BERR_EN
    // ---------------- bus-error timeout ----------------
    localparam int TW = $clog2(BERR_TIMEOUT);

    logic [TW-1:0] to_cnt;
    logic          berr_n_q;
    logic          to_run;

    assign to_run = (state == ST_WAIT) || (state == ST_DECODE && !lat_hit);

    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt   <= '0;
            berr_n_q <= 1'b1;
        end else if (bus.cpu_as_n) begin
            to_cnt   <= '0;
            berr_n_q <= 1'b1;
        end else if (to_run && berr_n_q) begin
            if (to_cnt == TW'(BERR_TIMEOUT - 1)) begin
                berr_n_q <= 1'b0;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end

    assign bus.berr_n = berr_n_q;
`endif

endmodule

// File: tb/tb_bus_decode_dtack.sv
// tb_bus_decode_dtack: directed bench for bus_decode_dtack.
// The reference model tracks each bus cycle as "edges since the strobe was
// sampled" and derives the outputs arithmetically from it:
//   outputs valid from edge 1 on a hit, dtack at max(2+ws, first ext_ack edge).
// The model is checked on every clock. Hand-computed literals pin the key
// scenarios.
module tb_bus_decode_dtack;
    import bus_decode_pkg::*;

    localparam int NREG  = 16;
    localparam int AW    = 24;
    localparam int DBITS = 20;
    localparam int WSW   = 4;
    localparam int IW    = $clog2(NREG);
    localparam int EW    = NREG + IW + 3;
    localparam int NEVER = 1 << 30;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic            cfg_we = 1'b0;
    logic [IW-1:0]   cfg_idx = '0;
    logic [DBITS-1:0] cfg_start = '0;
    logic [DBITS-1:0] cfg_end = '0;
    logic [WSW-1:0]  cfg_ws = '0;
    logic            cfg_rd_en = 1'b0;
    logic            cfg_wr_en = 1'b0;
    logic            cfg_ext = 1'b0;
    logic            cfg_valid = 1'b0;
    state_t          dbg_state;

    bus_decode_dtack_if #(.NREG(NREG), .AW(AW)) bus ();

    bus_decode_dtack #(.NREG(NREG), .AW(AW), .DBITS(DBITS), .WSW(WSW)) dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_we    (cfg_we),
        .cfg_idx   (cfg_idx),
        .cfg_start (cfg_start),
        .cfg_end   (cfg_end),
        .cfg_ws    (cfg_ws),
        .cfg_rd_en (cfg_rd_en),
        .cfg_wr_en (cfg_wr_en),
        .cfg_ext   (cfg_ext),
        .cfg_valid (cfg_valid),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    int n_checks = 0;
    int n_err = 0;
    int edge_n = 0;
    int e0 = 0;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    int  r_start [NREG];
    int  r_end   [NREG];
    int  r_ws    [NREG];
    bit  r_rd    [NREG];
    bit  r_wr    [NREG];
    bit  r_ext   [NREG];
    bit  r_valid [NREG];

    bit  seen_reset = 1'b0;
    bit  m_active = 1'b0;
    int  m_k, m_idx, m_ws, m_ack_k, dk;
    bit  m_hit, m_ext;
    bit  s_rst, s_as_n, s_rw, s_ack, s_we;
    int  s_addr;
    logic [NREG-1:0] e_sel;
    logic [IW-1:0]   e_idx;
    logic            e_hit, e_dtack_n, e_berr_n;
    logic [EW-1:0]   exp_q [$];
    logic [EW-1:0]   exp_v;

    always @(posedge clk) begin
        s_rst  = reset;
        s_as_n = bus.cpu_as_n;
        s_rw   = bus.cpu_rw;
        s_ack  = bus.ext_ack;
        s_we   = cfg_we;
        s_addr = int'(bus.cpu_a) % (1 << DBITS);
        if (s_rst) begin
            seen_reset = 1'b1;
            m_active = 1'b0;
            for (int i = 0; i < NREG; i++) r_valid[i] = 1'b0;
        end else begin
            if (!m_active) begin
                if (!s_as_n) begin
                    m_active = 1'b1;
                    m_k = 0;
                    m_ack_k = -1;
                    m_hit = 1'b0;
                    m_idx = 0;
                    for (int i = NREG - 1; i >= 0; i--) begin
                        if (r_valid[i] && s_addr >= r_start[i] && s_addr <= r_end[i] &&
                            (s_rw ? r_rd[i] : r_wr[i])) begin
                            m_hit = 1'b1;
                            m_idx = i;
                        end
                    end
                    m_ws = r_ws[m_idx];
                    m_ext = r_ext[m_idx];
                end
            end else if (s_as_n) begin
                m_active = 1'b0;
            end else begin
                m_k++;
                if (s_ack && m_ack_k < 0) m_ack_k = m_k;
            end
            if (s_we) begin
                r_start[cfg_idx] = int'(cfg_start);
                r_end[cfg_idx]   = int'(cfg_end);
                r_ws[cfg_idx]    = int'(cfg_ws);
                r_rd[cfg_idx]    = cfg_rd_en;
                r_wr[cfg_idx]    = cfg_wr_en;
                r_ext[cfg_idx]   = cfg_ext;
                r_valid[cfg_idx] = cfg_valid;
            end
        end
        e_sel = '0;
        e_idx = '0;
        e_hit = 1'b0;
        e_dtack_n = 1'b1;
        e_berr_n = 1'b1;
        dk = NEVER;
        if (m_active && m_hit) begin
            dk = 2 + m_ws;
            if (m_ext) dk = (m_ack_k < 0) ? NEVER : ((m_ack_k > dk) ? m_ack_k : dk);
        end
        if (m_active && m_hit && m_k >= 1) begin
            e_sel[m_idx] = 1'b1;
            e_idx = IW'(m_idx);
            e_hit = 1'b1;
            e_dtack_n = (m_k >= dk) ? 1'b0 : 1'b1;
        end
        if (m_active && ((!m_hit && m_k >= BERR_TIMEOUT) ||
                         (m_hit && m_k >= BERR_TIMEOUT + 1 && dk >= BERR_TIMEOUT + 1)))
            e_berr_n = 1'b0;
        exp_q.push_back({e_sel, e_idx, e_hit, e_dtack_n, e_berr_n});
        #1;
        exp_v = exp_q.pop_front();
        if (seen_reset) begin
            chk("sel",     32'(bus.sel),     32'(exp_v[EW-1 -: NREG]));
            chk("sel_idx", 32'(bus.sel_idx), 32'(exp_v[IW+2 : 3]));
            chk("hit",     32'(bus.hit),     32'(exp_v[2]));
            chk("dtack_n", 32'(bus.dtack_n), 32'(exp_v[1]));
`ifdef BUS_DECODE_BERR_EN
            chk("berr_n",  32'(bus.berr_n),  32'(exp_v[0]));
`endif
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cfg_write(input int idx, input int s, input int e, input int ws,
                             input bit rd, input bit wr, input bit ext);
        @(negedge clk);
        cfg_we    = 1'b1;
        cfg_idx   = IW'(idx);
        cfg_start = DBITS'(s);
        cfg_end   = DBITS'(e);
        cfg_ws    = WSW'(ws);
        cfg_rd_en = rd;
        cfg_wr_en = wr;
        cfg_ext   = ext;
        cfg_valid = 1'b1;
        @(negedge clk);
        cfg_we    = 1'b0;
    endtask

    // Strobe goes low; returns just after the edge that samples it (edge 0).
    task automatic as_low(input int addr, input bit rw);
        @(negedge clk);
        bus.cpu_a    = AW'(addr);
        bus.cpu_rw   = rw;
        bus.cpu_as_n = 1'b0;
        @(posedge clk);
        #1;
        e0 = edge_n;
    endtask

    // Returns shortly after edge e0+k.
    task automatic at_edge(input int k);
        while (edge_n < e0 + k) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic as_high();
        @(negedge clk);
        bus.cpu_as_n = 1'b1;
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_ack();
        @(negedge clk);
        bus.ext_ack = 1'b1;
        @(negedge clk);
        bus.ext_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        bus.cpu_a    = '0;
        bus.cpu_as_n = 1'b1;
        bus.cpu_rw   = 1'b1;
        bus.ext_ack  = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_sel",     32'(bus.sel), 32'h0);
        chk("rst_idx",     32'(bus.sel_idx), 32'h0);
        chk("rst_hit",     32'(bus.hit), 32'h0);
        chk("rst_dtack_n", 32'(bus.dtack_n), 32'h1);
        chk("rst_state",   32'(dbg_state), 32'(ST_IDLE));
        @(negedge clk);
        reset = 1'b0;

        cfg_write(0, 'h00000, 'h7FFFF, 0, 1, 1, 0);
        cfg_write(1, 'h80000, 'h8FFFF, 1, 1, 1, 0);
        cfg_write(2, 'h88000, 'h8BFFF, 0, 1, 1, 0);
        cfg_write(3, 'hF0000, 'hFFFFF, 3, 1, 1, 0);
        cfg_write(4, 'hA0000, 'hAFFFF, 2, 1, 1, 1);
        cfg_write(5, 'hC0000, 'hC0FFF, 0, 1, 0, 0);

        // ws=0 read in entry 0
        as_low('h012340, 1'b1);
        at_edge(1);
        chk("s032_sel",   32'(bus.sel), 32'h0001);
        chk("s032_dtk1",  32'(bus.dtack_n), 32'h1);
        at_edge(2);
        chk("s032_dtk2",  32'(bus.dtack_n), 32'h0);
        as_high();
        chk("s032_end_sel", 32'(bus.sel), 32'h0);
        chk("s032_end_dtk", 32'(bus.dtack_n), 32'h1);

        // back-to-back write cycle, no extra idle clock
        as_low('h000100, 1'b0);
        at_edge(1);
        chk("b2b_sel", 32'(bus.sel), 32'h0001);
        at_edge(2);
        chk("b2b_dtk", 32'(bus.dtack_n), 32'h0);
        as_high();

        // mirrored address, ws=3
        as_low('h1F0010, 1'b1);
        at_edge(1);
        chk("s033_hit", 32'(bus.hit), 32'h1);
        chk("s033_idx", 32'(bus.sel_idx), 32'h3);
        at_edge(4);
        chk("s033_dtk4", 32'(bus.dtack_n), 32'h1);
        at_edge(5);
        chk("s033_dtk5", 32'(bus.dtack_n), 32'h0);
        as_high();

        // overlapping entries 1 and 2: lowest wins
        as_low('h088000, 1'b1);
        at_edge(1);
        chk("s034_sel", 32'(bus.sel), 32'h0002);
        chk("s034_idx", 32'(bus.sel_idx), 32'h1);
        at_edge(3);
        chk("s034_dtk", 32'(bus.dtack_n), 32'h0);
        as_high();

        // ext region, early ack pulse remembered
        as_low('h0A0100, 1'b1);
        pulse_ack();
        at_edge(3);
        chk("s035_dtk3", 32'(bus.dtack_n), 32'h1);
        at_edge(4);
        chk("s035_dtk4", 32'(bus.dtack_n), 32'h0);
        as_high();

        // ext region, late ack decides
        as_low('h0A0000, 1'b1);
        at_edge(6);
        chk("late_dtk6", 32'(bus.dtack_n), 32'h1);
        pulse_ack();
        at_edge(7);
        chk("late_dtk7", 32'(bus.dtack_n), 32'h0);
        as_high();

        // abort in WAIT: never acknowledged
        as_low('h0F8000, 1'b1);
        at_edge(3);
        as_high();
        chk("abort_dtk", 32'(bus.dtack_n), 32'h1);
        chk("abort_sel", 32'(bus.sel), 32'h0);

        // table write during a cycle only affects the next cycle
        as_low('h0D0000, 1'b1);
        cfg_write(6, 'hD0000, 'hDFFFF, 1, 1, 1, 0);
        at_edge(4);
        chk("latch_miss", 32'(bus.hit), 32'h0);
        as_high();
        as_low('h0D0000, 1'b1);
        at_edge(1);
        chk("latch_hit", 32'(bus.hit), 32'h1);
        chk("latch_idx", 32'(bus.sel_idx), 32'h6);
        at_edge(3);
        chk("latch_dtk", 32'(bus.dtack_n), 32'h0);
        as_high();

        // write to a read-only region
        as_low('h0C0010, 1'b0);
        at_edge(1);
        chk("s036_hit", 32'(bus.hit), 32'h0);
        at_edge(20);
        chk("s036_dtk", 32'(bus.dtack_n), 32'h1);
`ifdef BUS_DECODE_BERR_EN
        at_edge(255);
        chk("s036_berr255", 32'(bus.berr_n), 32'h1);
        at_edge(256);
        chk("s036_berr256", 32'(bus.berr_n), 32'h0);
`endif
        as_high();

        // reset while waiting
        as_low('h0F0000, 1'b1);
        at_edge(2);
        chk("s037_in_wait", 32'(dbg_state), 32'(ST_WAIT));
        @(negedge clk);
        reset = 1'b1;
        bus.cpu_as_n = 1'b1;
        @(posedge clk);
        #2;
        chk("s037_sel",   32'(bus.sel), 32'h0);
        chk("s037_hit",   32'(bus.hit), 32'h0);
        chk("s037_dtk",   32'(bus.dtack_n), 32'h1);
        chk("s037_state", 32'(dbg_state), 32'(ST_IDLE));
        @(negedge clk);
        reset = 1'b0;
        as_low('h012340, 1'b1);
        at_edge(1);
        chk("s037_invalid", 32'(bus.hit), 32'h0);
        at_edge(3);
        chk("s037_nodtk", 32'(bus.dtack_n), 32'h1);
        as_high();

        repeat (2) @(posedge clk);
        #3;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
